// File: rtl/core_pkg.sv
// Shared core definitions: ALU / M-extension opcode numbers and the
// multiply/divide FSM state encoding, used by decoder, ALU and muldiv_unit.
package core_pkg;

  localparam logic [5:0] OP_ADD    = 6'd5;
  localparam logic [5:0] OP_SUB    = 6'd6;
  localparam logic [5:0] OP_SLL    = 6'd7;
  localparam logic [5:0] OP_SLT    = 6'd8;
  localparam logic [5:0] OP_SLTU   = 6'd9;
  localparam logic [5:0] OP_XOR    = 6'd10;
  localparam logic [5:0] OP_SRL    = 6'd11;
  localparam logic [5:0] OP_SRA    = 6'd12;
  localparam logic [5:0] OP_OR     = 6'd13;
  localparam logic [5:0] OP_AND    = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_AUIPC  = 6'd16;
  localparam logic [5:0] OP_JAL    = 6'd17;
  localparam logic [5:0] OP_JALR   = 6'd18;
  localparam logic [5:0] OP_BEQ    = 6'd19;
  localparam logic [5:0] OP_BNE    = 6'd20;
  localparam logic [5:0] OP_BLT    = 6'd21;
  localparam logic [5:0] OP_BGE    = 6'd22;
  localparam logic [5:0] OP_BLTU   = 6'd23;
  localparam logic [5:0] OP_BGEU   = 6'd24;
  localparam logic [5:0] OP_LOAD   = 6'd25;
  localparam logic [5:0] OP_STORE  = 6'd26;
  localparam logic [5:0] OP_FENCE  = 6'd27;
  localparam logic [5:0] OP_MUL    = 6'd28;
  localparam logic [5:0] OP_MULH   = 6'd29;
  localparam logic [5:0] OP_MULHSU = 6'd30;
  localparam logic [5:0] OP_MULHU  = 6'd31;
  localparam logic [5:0] OP_DIV    = 6'd32;
  localparam logic [5:0] OP_DIVU   = 6'd33;
  localparam logic [5:0] OP_REM    = 6'd34;
  localparam logic [5:0] OP_REMU   = 6'd35;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [5:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic a_signed(input logic [5:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [5:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, sharing one 64-bit accumulator; fixed 33-cycle latency.
module muldiv_unit
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_t   state, state_nxt;
  logic [5:0]  op_q;
  logic [31:0] a_q, b_q, mag_q;
  logic [63:0] acc, acc_nxt;
  logic [4:0]  cnt;
  logic [31:0] res_nxt;

  logic        accept, last;
  logic        sa_in, sb_in, sa, sb;
  logic [31:0] amag_in, bmag_in;

  assign accept = (state == ST_IDLE) && start && is_muldiv(opcode);
  assign last   = (state == ST_CALC) && (cnt == 5'(MD_ITERS - 1));
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  assign sa_in   = a[31] & a_signed(opcode);
  assign sb_in   = b[31] & b_signed(opcode);
  assign amag_in = sa_in ? -a : a;
  assign bmag_in = sb_in ? -b : b;
  assign sa      = a_q[31] & a_signed(op_q);
  assign sb      = b_q[31] & b_signed(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: if (last)   state_nxt = ST_DONE;
      ST_DONE:             state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // One iteration: multiply adds the multiplicand into the top half and
  // shifts right; divide shifts left and subtracts using a 33-bit partial
  // remainder so unsigned divisors above 2^31 still work.
  logic [32:0] msum;
  logic [33:0] ddiff;
  always_comb begin
    msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_q} : 33'd0);
    ddiff   = {1'b0, acc[63:31]} - {2'b00, mag_q};
    acc_nxt = acc;
    if (is_div(op_q))
      acc_nxt = ddiff[33] ? {acc[62:0], 1'b0} : {ddiff[31:0], acc[30:0], 1'b1};
    else
      acc_nxt = {msum, acc[31:1]};
  end

  logic [63:0] prod;
  logic [31:0] quo, rem;
  always_comb begin
    prod    = (sa ^ sb) ? -acc_nxt : acc_nxt;
    quo     = (sa ^ sb) ? -acc_nxt[31:0] : acc_nxt[31:0];
    rem     = sa ? -acc_nxt[63:32] : acc_nxt[63:32];
    res_nxt = prod[31:0];
    case (op_q)
      OP_MUL:                      res_nxt = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_nxt = prod[63:32];
      OP_DIV, OP_DIVU:             res_nxt = (b_q == 32'd0) ? 32'hFFFF_FFFF : quo;
      OP_REM, OP_REMU:             res_nxt = (b_q == 32'd0) ? a_q : rem;
      default:                     res_nxt = prod[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mag_q  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= opcode;
      a_q   <= a;
      b_q   <= b;
      cnt   <= '0;
      mag_q <= is_div(opcode) ? bmag_in : amag_in;
      acc   <= {32'd0, is_div(opcode) ? amag_in : bmag_in};
    end else if (state == ST_CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + 5'd1;
      if (last) result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, corner cases,
// busy/DONE start rejection and mid-operation reset.
module tb_muldiv_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op and follow it to completion; latency counts the cycle
  // after the sampling edge as cycle 1.
  task automatic run_op(input string tag, input logic [5:0] op,
                        input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] exp);
    int lat;
    logic [31:0] prev;
    lat = 0;
    @(negedge clk);
    prev = result;
    start = 1'b1; opcode = op; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 16) chk({tag, "_hold"}, result, prev);
      if (done) begin lat = k + 1; break; end
    end
    chk({tag, "_lat"}, lat, 32'd33);
    chk({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat, npulse;
    logic [31:0] prev;

    #12;
    chk("rst_out", {30'd0, busy, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul7x6",   OP_MUL,    32'd7,          32'd6,          32'd42);
    run_op("mulffff",  OP_MUL,    32'h0000FFFF,   32'h0000FFFF,   32'hFFFE0001);
    run_op("mulh",     OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h0);
    run_op("mulhu",    OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE);
    run_op("mulhsu",   OP_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF);
    run_op("div_m7_2", OP_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD);
    run_op("rem_m7_2", OP_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF);
    run_op("div_7_m2", OP_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD);
    run_op("rem_7_m2", OP_REM,    32'd7,          32'hFFFFFFFE,   32'd1);
    run_op("divu_100", OP_DIVU,   32'd100,        32'd7,          32'd14);
    run_op("remu_100", OP_REMU,   32'd100,        32'd7,          32'd2);
    run_op("divu_max", OP_DIVU,   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF);
    run_op("remu_big", OP_REMU,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1);
    run_op("divu_z",   OP_DIVU,   32'd7,          32'd0,          32'hFFFFFFFF);
    run_op("remu_z",   OP_REMU,   32'd7,          32'd0,          32'd7);
    run_op("div_z",    OP_DIV,    32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF);
    run_op("rem_z",    OP_REM,    32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9);
    run_op("div_ovf",  OP_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000);
    run_op("rem_ovf",  OP_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0);

    // Non-M opcodes are ignored and leave outputs alone.
    @(negedge clk);
    prev = result;
    start = 1'b1; opcode = OP_ADD; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    chk("badop5_busy", {31'd0, busy}, 32'd0);
    opcode = 6'd36;
    @(posedge clk); #1;
    start = 1'b0;
    chk("badop36_busy", {31'd0, busy}, 32'd0);
    chk("badop_res", result, prev);

    // Start during CALC and during DONE must both be dropped.
    @(negedge clk);
    start = 1'b1; opcode = OP_DIV; a = 32'hFFFFFF9C; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin start = 1'b1; opcode = OP_DIV; a = 32'd1000; b = 32'd3; end
      if (k == 11) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = k + 1; break; end
    end
    chk("busydiv_lat", lat, 32'd33);
    chk("busydiv_res", result, 32'hFFFFFFF2);
    start = 1'b1; opcode = OP_MUL; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("donestart_busy", {31'd0, busy}, 32'd0);
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    chk("busydiv_nodone", npulse, 32'd0);
    chk("busydiv_hold", result, 32'hFFFFFFF2);

    // Reset in the middle of a multiply aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", {30'd0, busy, done}, 32'd0);
    chk("abort_res", result, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    chk("abort_nodone", npulse, 32'd0);
    run_op("after_rst", OP_MUL, 32'd9, 32'd9, 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 opcode  input  6  operation code: 28 MUL, 29 MULH, 30 MULHSU, 31 MULHU, 32 DIV, 33 DIVU, 34 REM, 35 REMU.
REQ-006 a  input  32  operand rs1 (same source as the ALU a operand).
REQ-007 b  input  32  operand rs2 (same source as the ALU b operand).
REQ-008 busy  output  1  high while an operation is in flight (CALC or DONE).
REQ-009 done  output  1  single-cycle result-valid strobe.
REQ-010 result  output  32  operation result; feeds the writeback mux alongside the ALU output.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE; busy = (state != IDLE); done = (state == DONE).
REQ-012 In IDLE, start=1 with opcode in 28..35 SHALL latch a, b and opcode, clear the 5-bit iteration counter and enter CALC at that edge.
REQ-013 start with opcode outside 28..35 SHALL be ignored; the FSM stays in IDLE and all outputs hold.
REQ-014 start while busy=1 SHALL be ignored; the latched operands and opcode SHALL not change.
REQ-015 CALC SHALL last exactly 32 cycles, one iteration per cycle, then move to DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-016 Latency SHALL be fixed for every opcode and operand: done high in the 33rd cycle after the edge that sampled start.
REQ-017 Multiply SHALL use radix-2 shift-add on operand magnitudes into a 64-bit product, with sign correction applied on the CALC->DONE edge.
REQ-018 MUL SHALL return product[31:0]; MULH signed x signed [63:32]; MULHSU signed a x unsigned b [63:32]; MULHU unsigned x unsigned [63:32].
REQ-019 Divide SHALL use radix-2 restoring division on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); signed only for DIV/REM.
REQ-020 Divide by zero SHALL return quotient 32'hFFFFFFFF (DIV and DIVU) and remainder = a (REM and REMU).
REQ-021 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF) SHALL return DIV 32'h80000000 and REM 0.
REQ-022 result SHALL load on the CALC->DONE edge and hold until the next accepted start loads a new value; it SHALL not change during CALC.
REQ-023 start sampled in the DONE cycle SHALL be ignored; the next accepted start is in IDLE, giving a minimum issue interval of 34 cycles.

Reset
REQ-024 rst_n low SHALL asynchronously force state to IDLE, busy=0, done=0, result=0 and clear the counter and internal accumulators.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse; operation resumes only on a new start after release.

Structure
REQ-026 Opcode constants 5..35 (ALU and M-extension codes) and the FSM state encoding SHALL live in a shared package, core_pkg, used by the decoder, the ALU and this block.
REQ-027 The block SHALL be a single module with no sub-module; the multiplier and divider SHALL share the 64-bit accumulator and the counter.

Verification
REQ-028 MUL a=7, b=6 -> busy=1 next cycle; done=1 exactly 33 cycles after start with result=42; busy=0 the cycle after.
REQ-029 MULH a=32'hFFFFFFFF, b=32'hFFFFFFFF -> result 0; MULHU with the same operands -> 32'hFFFFFFFE; MULHSU a=-1, b=2 -> 32'hFFFFFFFF.
REQ-030 DIV a=-7, b=2 -> 32'hFFFFFFFD; REM -> 32'hFFFFFFFF; DIVU a=7, b=0 -> 32'hFFFFFFFF; REMU a=7, b=0 -> 7.
REQ-031 DIV a=32'h80000000, b=32'hFFFFFFFF -> 32'h80000000; REM with the same operands -> 0; latency still 33 cycles.
REQ-032 Second start at cycle 10 of a DIV, with different operands -> ignored; first result correct; no extra done pulse.
REQ-033 rst_n low at cycle 15 of a MUL -> busy=0, done=0, result=0 immediately; no done pulse after release; a new start completes correctly.
